subtrator_serial: RTL and testbench

Bit-serial N-bit subtractor computing D = A − B − bin one bit per clock, LSB first, through a single full-subtractor stage and a registered borrow. It is the inverse arithmetic partner of the team's full-adder cell. It trades N cycles of latency for one-bit datapath logic, and reports completion with a start/done handshake. A bench can compare it directly against the ripple adder identity A − B = A + ~B + 1.

---
 rtl/subtrator_serial_if.sv | 23 ++
 rtl/subtrator_serial.sv | 89 ++++++++
 tb/tb_subtrator_serial.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/subtrator_serial_if.sv
// Request/result bundle for the bit-serial subtractor.
// Handshake: start is sampled only while idle; done pulses for one cycle when d/bout are fresh.
interface subtrator_serial_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bout;
  logic [1:0]   state;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, state
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, state
  );
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: D = A - B - bin, LSB first, one full-subtractor
// stage and a registered borrow; start/done handshake, state visible on bus.state.
module subtrator_serial #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst,
  subtrator_serial_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [N-1:0]  ra, rb, rd;
  logic          br;
  logic [CW-1:0] cnt;
  logic [N-1:0]  d_q;
  logic          bout_q;

  logic          x, y, diff, br_next, last;
  logic [N-1:0]  rd_next;

  // One full-subtractor stage on the current LSBs.
  always_comb begin
    x       = ra[0];
    y       = rb[0];
    diff    = x ^ y ^ br;
    br_next = (~x & y) | (~(x ^ y) & br);
    rd_next = {diff, rd[N-1:1]};
    last    = (cnt == CW'(N - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (bus.start) begin
          ra  <= bus.a;
          rb  <= bus.b;
          br  <= bus.bin;
          cnt <= '0;
        end
        SHIFT: begin
          ra  <= {1'b0, ra[N-1:1]};
          rb  <= {1'b0, rb[N-1:1]};
          rd  <= rd_next;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          // Results are published only once the final bit is in.
          if (last) begin
            d_q    <= rd_next;
            bout_q <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state == SHIFT);
  assign bus.done  = (state == DONE);
  assign bus.d     = d_q;
  assign bus.bout  = bout_q;
  assign bus.state = state;
endmodule

// File: tb/tb_subtrator_serial.sv
// Directed bench for subtrator_serial (N=4): reset, single ops, ignored inputs,
// mid-operation reset and an exhaustive back-to-back sweep with a scoreboard.
module tb_subtrator_serial;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   cycle_cnt;
  logic [N:0] exp_q[$];

  subtrator_serial_if #(.N(N)) bus ();

  subtrator_serial #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and free-running cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Driver: present an operation at a negedge; the following posedge accepts it.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", bus.busy); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d expected 0", bus.done); end
    n_cmp++;
    if (bus.d !== 4'd0) begin n_fail++; $display("FAIL reset_d: got %0d expected 0", bus.d); end
    n_cmp++;
    if (bus.bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %0d expected 0", bus.bout); end
    n_cmp++;
    if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 9 - 3 - 0: busy for 4 cycles, done for one, result held while idle.
  task automatic test_basic();
    launch(4'd9, 4'd3, 1'b0);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++; $display("FAIL basic_busy[%0d]: got busy=%0d done=%0d expected busy=1 done=0", i, bus.busy, bus.done);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got done=%0d busy=%0d expected done=1 busy=0", bus.done, bus.busy);
    end
    n_cmp++;
    if (bus.d !== 4'd6 || bus.bout !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: got d=%0d bout=%0d expected d=6 bout=0", bus.d, bus.bout);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got done=%0d expected 0", bus.done); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.d !== 4'd6 || bus.bout !== 1'b0 || bus.state !== 2'd0) begin
      n_fail++; $display("FAIL basic_hold: got d=%0d bout=%0d state=%0d expected d=6 bout=0 state=0", bus.d, bus.bout, bus.state);
    end
  endtask

  // Hand-computed vectors: {a, b, bin, d, bout}.
  task automatic test_vectors();
    logic [N-1:0] va[3]  = '{4'd3, 4'd0, 4'd15};
    logic [N-1:0] vb[3]  = '{4'd9, 4'd0, 4'd15};
    logic         vi[3]  = '{1'b0, 1'b1, 1'b0};
    logic [N-1:0] vd[3]  = '{4'd10, 4'd15, 4'd0};
    logic         vo[3]  = '{1'b1, 1'b1, 1'b0};
    int cyc;
    for (int k = 0; k < 3; k++) begin
      launch(va[k], vb[k], vi[k]);
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 12) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (cyc != N + 1) begin
        n_fail++; $display("FAIL vec_latency[%0d]: got %0d cycles expected %0d", k, cyc, N + 1);
      end
      n_cmp++;
      if (bus.d !== vd[k] || bus.bout !== vo[k]) begin
        n_fail++; $display("FAIL vec_result[%0d]: got d=%0d bout=%0d expected d=%0d bout=%0d", k, bus.d, bus.bout, vd[k], vo[k]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  // start/operand changes during SHIFT must not disturb the 13-4-1 op.
  task automatic test_ignore();
    int dones;
    logic [N-1:0] got_d;
    logic got_b;
    dones = 0;
    got_d = '0;
    got_b = 1'b0;
    launch(4'd13, 4'd4, 1'b1);
    @(negedge clk);
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) begin dones++; got_d = bus.d; got_b = bus.bout; end
      @(negedge clk);
    end
    n_cmp++;
    if (dones != 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", dones); end
    n_cmp++;
    if (got_d !== 4'd8 || got_b !== 1'b0) begin
      n_fail++; $display("FAIL ignore_result: got d=%0d bout=%0d expected d=8 bout=0", got_d, got_b);
    end
  endtask

  // Reset applied at E2 of an operation discards it.
  task automatic test_reset_mid();
    int dones;
    dones = 0;
    launch(4'd2, 4'd9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.d !== 4'd0 || bus.bout !== 1'b0 || bus.state !== 2'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy=%0d done=%0d d=%0d bout=%0d state=%0d expected all 0",
                         bus.busy, bus.done, bus.d, bus.bout, bus.state);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    n_cmp++;
    if (dones != 0) begin n_fail++; $display("FAIL midrst_nodone: got %0d pulses expected 0", dones); end
    launch(4'd7, 4'd2, 1'b1);
    repeat (N) @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.d !== 4'd4 || bus.bout !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: got done=%0d d=%0d bout=%0d expected done=1 d=4 bout=0", bus.done, bus.d, bus.bout);
    end
    repeat (2) @(negedge clk);
  endtask

  // All 512 {a,b,bin} combinations with start held high; scoreboard plus
  // adder-identity cross-check and done-to-done spacing.
  task automatic test_back_to_back();
    logic [8:0]   idx;
    logic [N:0]   exp;
    logic [N:0]   fa;
    logic [N-1:0] nb;
    logic         nbin;
    logic [N-1:0] cur_a, cur_b;
    logic         cur_bin;
    int           cyc;
    int           last_done;
    last_done = 0;
    idx = 9'd0;
    cur_a = idx[8:5]; cur_b = idx[4:1]; cur_bin = idx[0];
    bus.a = cur_a; bus.b = cur_b; bus.bin = cur_bin;
    bus.start = 1'b1;
    exp_q.push_back({({1'b0, cur_a} < ({1'b0, cur_b} + {4'd0, cur_bin})), 4'(cur_a - cur_b - {3'd0, cur_bin})});
    for (int i = 0; i < 512; i++) begin
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (bus.done !== 1'b1) begin
        n_fail++; $display("FAIL sweep_timeout[%0d]: got no done in %0d cycles expected done", i, cyc);
        bus.start = 1'b0;
        return;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if ({bus.bout, bus.d} !== exp) begin
        n_fail++; $display("FAIL sweep_result[%0d]: got d=%0d bout=%0d expected d=%0d bout=%0d",
                           i, bus.d, bus.bout, exp[N-1:0], exp[N]);
      end
      nb   = ~cur_b;
      nbin = ~cur_bin;
      fa   = {1'b0, cur_a} + {1'b0, nb} + {4'd0, nbin};
      n_cmp++;
      if (bus.d !== fa[N-1:0] || bus.bout !== ~fa[N]) begin
        n_fail++; $display("FAIL sweep_adder[%0d]: got d=%0d bout=%0d expected sum=%0d ~carry=%0d",
                           i, bus.d, bus.bout, fa[N-1:0], ~fa[N]);
      end
      if (i > 0) begin
        n_cmp++;
        if (cycle_cnt - last_done != N + 2) begin
          n_fail++; $display("FAIL sweep_spacing[%0d]: got %0d expected %0d", i, cycle_cnt - last_done, N + 2);
        end
      end
      last_done = cycle_cnt;
      if (i < 511) begin
        idx = 9'(i + 1);
        cur_a = idx[8:5]; cur_b = idx[4:1]; cur_bin = idx[0];
        bus.a = cur_a; bus.b = cur_b; bus.bin = cur_bin;
        exp_q.push_back({({1'b0, cur_a} < ({1'b0, cur_b} + {4'd0, cur_bin})), 4'(cur_a - cur_b - {3'd0, cur_bin})});
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sweep_queue: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
